alu_share_arb: RTL and testbench
================================

Name: alu_share_arb

Overview:
- Round-robin arbiter/sequencer sharing one simple_alu instance between N_REQ requesters.
- Each requester submits {op, a, b} over a valid/ready handshake. The block drives the ALU enable sequence (en_i, then en_o), captures out, and returns the result on a per-requester response handshake.
- Sits between requester blocks and the single simple_alu; it is the only driver of the ALU inputs.

Parameters:
- N_REQ, 4, number of requesters; legal range 1..16.
- DATA_W, 4, operand/result width; must match ALU a/b/out.
- OP_W, 2, opcode width; must match ALU select_op.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid_i  input  N_REQ  per-requester request valid.
- req_ready_o  output  N_REQ  per-requester accept; one-hot or zero.
- req_op_i  input  N_REQ*OP_W  opcode; requester k in slice [k*OP_W +: OP_W].
- req_a_i  input  N_REQ*DATA_W  operand a, sliced as for op.
- req_b_i  input  N_REQ*DATA_W  operand b, sliced as for op.
- rsp_valid_o  output  N_REQ  result valid; one-hot or zero.
- rsp_ready_i  input  N_REQ  per-requester result accept.
- rsp_data_o  output  DATA_W  result, shared by all requesters; qualified by rsp_valid_o.
- alu_en_i_o  output  1  to ALU en_i.
- alu_en_o_o  output  1  to ALU en_o.
- alu_sel_o  output  OP_W  to ALU select_op.
- alu_a_o  output  DATA_W  to ALU a.
- alu_b_o  output  DATA_W  to ALU b.
- alu_out_i  input  DATA_W  from ALU out.
- busy_o  output  1  high in any state except IDLE.

Behaviour:
- Reset (async, immediate):
  - state=IDLE; all outputs 0.
  - Latched op/a/b = 0; rsp_data = 0.
  - last_grant = N_REQ-1, so requester 0 wins first.
- FSM states: IDLE -> ISSUE -> EXEC -> CAPTURE -> RESP -> IDLE. One cycle each, except IDLE and RESP.
- IDLE:
  - Winner = first k with req_valid_i[k]=1, scanning from (last_grant+1) mod N_REQ upward with wrap.
  - req_ready_o[winner]=1 combinationally, only in IDLE.
  - On that edge: latch winner's op/a/b, owner=winner, go ISSUE.
  - No valid: stay in IDLE, all ready=0.
- ISSUE: alu_en_i_o=1; alu_sel_o/alu_a_o/alu_b_o = latched values.
- EXEC: alu_en_o_o=1; ALU operand outputs held.
- CAPTURE: rsp_data <= alu_out_i on exit edge.
- RESP:
  - rsp_valid_o[owner]=1; rsp_data_o stable.
  - Stays in RESP until rsp_ready_i[owner]=1.
  - On that edge: last_grant<=owner, go IDLE.
  - rsp_ready_i of non-owners is ignored.
- Timing:
  - Accept edge -> rsp_valid_o high after 3 edges.
  - Minimum 5 cycles per operation, including the IDLE arbitration cycle.
- ALU outputs outside ISSUE/EXEC: alu_en_* = 0. Sel/a/b hold last latched values, not toggled.
- Requester protocol:
  - Valid may drop before ready with no effect.
  - After ready, the request is consumed; payload may change.
  - A requester may raise a new valid while its response is pending; it is not served until IDLE.
- Priority: a requester re-requesting continuously gets at most one grant per N_REQ grants while others are valid.
- N_REQ=1: pointer degenerates; requester 0 is always granted.
- Reset mid-operation: operation aborted, no response, ALU enables drop asynchronously.
- Pointer width $clog2(N_REQ), minimum 1 bit. Wrap N_REQ-1 -> 0 must be correct for non-power-of-2 N_REQ.

Optional Feature:
- Macro ALU_SHARE_PRIO0_EN.
- Defined: requester 0 is high priority. If req_valid_i[0]=1 in IDLE, it wins regardless of pointer, and last_grant is not updated by requester-0 grants. Others arbitrate round-robin among themselves.
- Undefined: pure round-robin as above.

Test Plan:
- Reset, then single request: req 2 valid, op=2'b00, a=4'h1, b=4'h3; bench ALU model out=a+b registered on en_o.
  -> ready[2] in the same cycle; alu_en_i 1 cycle, then alu_en_o 1 cycle; rsp_valid_o=4'b0100 three edges after accept, rsp_data_o=4'h4.
- All four valid continuously, rsp_ready_i tied high -> grant order 0,1,2,3,0; one accept per 5 cycles.
- Response backpressure: rsp_ready_i low for 6 cycles.
  -> rsp_valid_o and rsp_data_o held stable, no new ready, busy_o=1; completes on the first ready cycle.
- Valid withdrawn: req 1 raises valid while busy, drops it before IDLE -> never granted, no response to 1.
- Reset asserted during EXEC -> alu_en_o_o, busy_o, rsp_valid_o go to 0 immediately; after release, requester 0 is granted first.
- With ALU_SHARE_PRIO0_EN and reqs 0,1,3 valid continuously -> requester 0 granted every operation. Without the macro -> order 0,1,3,0.

Source files
------------

// File: rtl/alu_share_arb.sv
// alu_share_arb: round-robin sequencer that shares one simple_alu between
// N_REQ requesters. Each operation walks IDLE -> ISSUE -> EXEC -> CAPTURE ->
// RESP. The grant is made in IDLE, the ALU gets en_i then en_o, the ALU
// result is captured, and it is held on the owner's response channel until
// the owner accepts it.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. Request valid may drop before ready with no effect; once
// ready was seen, the payload has been consumed. Response valid stays high
// with stable data until the owner's rsp_ready_i is high.
//
// Optional feature: define ALU_SHARE_PRIO0_EN to make requester 0 win every
// arbitration it takes part in, without moving the round-robin pointer.
module alu_share_arb #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 4,
    parameter int OP_W   = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req_valid_i,
    output logic [N_REQ-1:0]         req_ready_o,
    input  logic [N_REQ*OP_W-1:0]    req_op_i,
    input  logic [N_REQ*DATA_W-1:0]  req_a_i,
    input  logic [N_REQ*DATA_W-1:0]  req_b_i,
    output logic [N_REQ-1:0]         rsp_valid_o,
    input  logic [N_REQ-1:0]         rsp_ready_i,
    output logic [DATA_W-1:0]        rsp_data_o,
    output logic                     alu_en_i_o,
    output logic                     alu_en_o_o,
    output logic [OP_W-1:0]          alu_sel_o,
    output logic [DATA_W-1:0]        alu_a_o,
    output logic [DATA_W-1:0]        alu_b_o,
    input  logic [DATA_W-1:0]        alu_out_i,
    output logic                     busy_o
);

    // Pointer is at least one bit wide so N_REQ=1 still has a legal vector.
    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_EXEC    = 3'd2,
        S_CAPTURE = 3'd3,
        S_RESP    = 3'd4
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [PTR_W-1:0]     last_grant;
    logic [PTR_W-1:0]     owner;
    logic [PTR_W-1:0]     winner;
    logic [PTR_W-1:0]     cand;
    logic                 win_found;
    logic [OP_W-1:0]      op_q;
    logic [DATA_W-1:0]    a_q;
    logic [DATA_W-1:0]    b_q;
    logic [DATA_W-1:0]    rsp_data_q;

    // Modulo-N_REQ increment; correct for non-power-of-two N_REQ because the
    // wrap is an explicit compare rather than relying on pointer overflow.
    function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base,
                                                  input int step);
        int sum;
        sum = int'(base) + step;
        if (sum >= N_REQ) sum = sum - N_REQ;
        return PTR_W'(sum);
    endfunction

    // Arbitration: first valid requester after last_grant, scanning with wrap.
    always_comb begin
        winner    = '0;
        cand      = '0;
        win_found = 1'b0;
        for (int i = 1; i <= N_REQ; i++) begin
            cand = wrap_add(last_grant, i);
            if (!win_found && req_valid_i[cand]) begin
                winner    = cand;
                win_found = 1'b1;
            end
        end
`ifdef ALU_SHARE_PRIO0_EN
        if (req_valid_i[0]) begin
            winner    = '0;
            win_found = 1'b1;
        end
`else
`endif
    end

    // FSM next state and all handshake / ALU enable outputs.
    always_comb begin
        state_nxt   = state;
        req_ready_o = '0;
        rsp_valid_o = '0;
        alu_en_i_o  = 1'b0;
        alu_en_o_o  = 1'b0;
        busy_o      = (state != S_IDLE);
        unique case (state)
            S_IDLE: begin
                if (win_found) begin
                    req_ready_o[winner] = 1'b1;
                    state_nxt           = S_ISSUE;
                end
            end
            S_ISSUE: begin
                alu_en_i_o = 1'b1;
                state_nxt  = S_EXEC;
            end
            S_EXEC: begin
                alu_en_o_o = 1'b1;
                state_nxt  = S_CAPTURE;
            end
            S_CAPTURE: begin
                state_nxt = S_RESP;
            end
            S_RESP: begin
                rsp_valid_o[owner] = 1'b1;
                if (rsp_ready_i[owner]) state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Datapath: latch the winner's payload, capture the ALU result, and
    // advance the round-robin pointer when the owner takes its response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= PTR_W'(N_REQ - 1);
            owner      <= '0;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            rsp_data_q <= '0;
        end else begin
            if (state == S_IDLE && win_found) begin
                owner <= winner;
                op_q  <= req_op_i[winner*OP_W +: OP_W];
                a_q   <= req_a_i[winner*DATA_W +: DATA_W];
                b_q   <= req_b_i[winner*DATA_W +: DATA_W];
            end
            if (state == S_CAPTURE) begin
                rsp_data_q <= alu_out_i;
            end
            if (state == S_RESP && rsp_ready_i[owner]) begin
`ifdef ALU_SHARE_PRIO0_EN
                if (owner != '0) last_grant <= owner;
`else
                last_grant <= owner;
`endif
            end
        end
    end

    // ALU operands hold the last latched payload between operations.
    assign alu_sel_o  = op_q;
    assign alu_a_o    = a_q;
    assign alu_b_o    = b_q;
    assign rsp_data_o = rsp_data_q;

endmodule

// File: tb/tb_alu_share_arb.sv
// Testbench for alu_share_arb with a behavioural ALU (out registered on en_o).
// Bench ALU opcodes: 00 add, 01 sub, 10 and, 11 xor.
// Build with +define+ALU_SHARE_PRIO0_EN to check the priority variant.
`timescale 1ns/1ps
module tb_alu_share_arb;

    localparam int N_REQ  = 4;
    localparam int DATA_W = 4;
    localparam int OP_W   = 2;
    localparam int W      = N_REQ + DATA_W;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic [N_REQ-1:0]        req_valid_i;
    logic [N_REQ-1:0]        req_ready_o;
    logic [N_REQ*OP_W-1:0]   req_op_i;
    logic [N_REQ*DATA_W-1:0] req_a_i;
    logic [N_REQ*DATA_W-1:0] req_b_i;
    logic [N_REQ-1:0]        rsp_valid_o;
    logic [N_REQ-1:0]        rsp_ready_i;
    logic [DATA_W-1:0]       rsp_data_o;
    logic                    alu_en_i_o;
    logic                    alu_en_o_o;
    logic [OP_W-1:0]         alu_sel_o;
    logic [DATA_W-1:0]       alu_a_o;
    logic [DATA_W-1:0]       alu_b_o;
    logic [DATA_W-1:0]       alu_out = '0;
    logic                    busy_o;

    int checks = 0;
    int failures = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] mon_exp;
    int grant_order[$];
    int grant_cyc[$];

    typedef struct {
        int                id;
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [DATA_W-1:0] exp;
    } vec_t;
    vec_t vec[6];

    logic [DATA_W-1:0] rr_exp[N_REQ];
    int exp_rr[5];
    int exp_prio[4];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    alu_share_arb #(.N_REQ(N_REQ), .DATA_W(DATA_W), .OP_W(OP_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_op_i    (req_op_i),
        .req_a_i     (req_a_i),
        .req_b_i     (req_b_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_data_o  (rsp_data_o),
        .alu_en_i_o  (alu_en_i_o),
        .alu_en_o_o  (alu_en_o_o),
        .alu_sel_o   (alu_sel_o),
        .alu_a_o     (alu_a_o),
        .alu_b_o     (alu_b_o),
        .alu_out_i   (alu_out),
        .busy_o      (busy_o)
    );

    function automatic logic [DATA_W-1:0] alu_model(input logic [OP_W-1:0] op,
                                                    input logic [DATA_W-1:0] a,
                                                    input logic [DATA_W-1:0] b);
        case (op)
            2'b00:   return a + b;
            2'b01:   return a - b;
            2'b10:   return a & b;
            default: return a ^ b;
        endcase
    endfunction

    // Behavioural ALU: result register loads on en_o.
    always @(posedge clk) begin
        if (alu_en_o_o) alu_out <= alu_model(alu_sel_o, alu_a_o, alu_b_o);
    end

    function automatic logic [N_REQ-1:0] onehot(input int k);
        logic [N_REQ-1:0] v;
        v = '0;
        v[k] = 1'b1;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    // Every completed response handshake must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && ((rsp_valid_o & rsp_ready_i) != '0)) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL rsp_unexpected: got valid=%b data=%h, expected no response",
                         rsp_valid_o, rsp_data_o);
            end else begin
                mon_exp = exp_q.pop_front();
                check("rsp", 32'({rsp_valid_o, rsp_data_o}), 32'(mon_exp));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req_valid_i = '0;
        rsp_ready_i = '1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic set_payload(input int id, input logic [OP_W-1:0] op,
                               input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        req_op_i[id*OP_W +: OP_W]     = op;
        req_a_i[id*DATA_W +: DATA_W]  = a;
        req_b_i[id*DATA_W +: DATA_W]  = b;
    endtask

    // Raise one request, wait (bounded) for ready, push its expected response.
    task automatic send(input int id, input logic [OP_W-1:0] op,
                        input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                        input logic [DATA_W-1:0] exp, input bit push);
        bit got;
        got = 1'b0;
        set_payload(id, op, a, b);
        req_valid_i[id] = 1'b1;
        for (int c = 0; c < 50 && !got; c++) begin
            #1;
            if (req_ready_o[id]) begin
                got = 1'b1;
                if (push) exp_q.push_back({onehot(id), exp});
            end
            @(posedge clk);
            #1;
        end
        req_valid_i[id] = 1'b0;
        check("send_granted", 32'(got), 32'd1);
    endtask

    task automatic wait_idle();
        for (int c = 0; c < 60 && busy_o; c++) tick();
        check("wait_idle", 32'(busy_o), 32'd0);
    endtask

    // Record grants (index and cycle) with the current valid pattern held.
    task automatic watch_grants(input int n);
        grant_order.delete();
        grant_cyc.delete();
        for (int c = 0; c < 200 && grant_order.size() < n; c++) begin
            #1;
            for (int k = 0; k < N_REQ; k++) begin
                if (req_ready_o[k]) begin
                    grant_order.push_back(k);
                    grant_cyc.push_back(c);
                    exp_q.push_back({onehot(k), rr_exp[k]});
                end
            end
            @(posedge clk);
            #1;
        end
        check("grant_count", 32'(grant_order.size()), 32'(n));
    endtask

    task automatic set_rr_payloads();
        for (int k = 0; k < N_REQ; k++) set_payload(k, 2'b00, 4'(k), 4'h1);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        vec[0] = '{0, 2'b00, 4'h7, 4'h8, 4'hF};
        vec[1] = '{1, 2'b01, 4'h3, 4'h5, 4'hE};
        vec[2] = '{2, 2'b10, 4'hC, 4'hA, 4'h8};
        vec[3] = '{3, 2'b11, 4'hF, 4'h5, 4'hA};
        vec[4] = '{3, 2'b00, 4'h9, 4'h9, 4'h2};
        vec[5] = '{1, 2'b11, 4'h6, 4'h3, 4'h5};
        rr_exp = '{4'h1, 4'h2, 4'h3, 4'h4};
        exp_rr = '{0, 1, 2, 3, 0};
`ifdef ALU_SHARE_PRIO0_EN
        exp_prio = '{0, 0, 0, 0};
`else
        exp_prio = '{0, 1, 3, 0};
`endif

        req_valid_i = '0;
        req_op_i    = '0;
        req_a_i     = '0;
        req_b_i     = '0;
        rsp_ready_i = '1;
        rst_n       = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Reset state.
        check("reset_req_ready", 32'(req_ready_o), 32'h0);
        check("reset_rsp_valid", 32'(rsp_valid_o), 32'h0);
        check("reset_busy",      32'(busy_o),      32'h0);
        check("reset_en_i",      32'(alu_en_i_o),  32'h0);
        check("reset_en_o",      32'(alu_en_o_o),  32'h0);
        check("reset_sel",       32'(alu_sel_o),   32'h0);
        check("reset_a",         32'(alu_a_o),     32'h0);
        check("reset_b",         32'(alu_b_o),     32'h0);
        check("reset_rsp_data",  32'(rsp_data_o),  32'h0);
        rst_n = 1'b1;
        tick();

        // Single request from requester 2: cycle-by-cycle sequence.
        set_payload(2, 2'b00, 4'h1, 4'h3);
        req_valid_i[2] = 1'b1;
        #1;
        check("single_ready", 32'(req_ready_o), 32'h4);
        exp_q.push_back({4'b0100, 4'h4});
        tick();
        req_valid_i[2] = 1'b0;
        check("issue_en_i", 32'(alu_en_i_o), 32'd1);
        check("issue_en_o", 32'(alu_en_o_o), 32'd0);
        check("issue_sel",  32'(alu_sel_o),  32'h0);
        check("issue_a",    32'(alu_a_o),    32'h1);
        check("issue_b",    32'(alu_b_o),    32'h3);
        tick();
        check("exec_en_i", 32'(alu_en_i_o), 32'd0);
        check("exec_en_o", 32'(alu_en_o_o), 32'd1);
        tick();
        check("capture_rsp_valid", 32'(rsp_valid_o), 32'h0);
        check("capture_en_o",      32'(alu_en_o_o),  32'd0);
        tick();
        check("resp_valid", 32'(rsp_valid_o), 32'h4);
        check("resp_data",  32'(rsp_data_o),  32'h4);
        wait_idle();

        // Table-driven single transactions.
        for (int i = 0; i < $size(vec); i++) begin
            send(vec[i].id, vec[i].op, vec[i].a, vec[i].b, vec[i].exp, 1'b1);
            wait_idle();
        end

        // Backpressure on requester 2; non-owner ready bits must be ignored,
        // and requester 1 raises then withdraws valid while busy.
        rsp_ready_i = 4'b1011;
        send(2, 2'b01, 4'h9, 4'h4, 4'h5, 1'b1);
        repeat (3) tick();
        req_valid_i[1] = 1'b1;
        for (int c = 0; c < 6; c++) begin
            check("bp_rsp_valid", 32'(rsp_valid_o), 32'h4);
            check("bp_rsp_data",  32'(rsp_data_o),  32'h5);
            check("bp_busy",      32'(busy_o),      32'd1);
            check("bp_no_ready",  32'(req_ready_o), 32'h0);
            tick();
        end
        req_valid_i[1] = 1'b0;
        rsp_ready_i = '1;
        tick();
        check("bp_done_busy",      32'(busy_o),      32'd0);
        check("bp_done_rsp_valid", 32'(rsp_valid_o), 32'h0);
        repeat (3) tick();
        check("withdrawn_no_ready", 32'(req_ready_o), 32'h0);

        // Reset during EXEC: aborted, enables drop at once, pointer restored.
        send(1, 2'b10, 4'hF, 4'h3, 4'h3, 1'b0);
        tick();
        check("abort_in_exec", 32'(alu_en_o_o), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_en_o",      32'(alu_en_o_o),  32'd0);
        check("abort_en_i",      32'(alu_en_i_o),  32'd0);
        check("abort_busy",      32'(busy_o),      32'd0);
        check("abort_rsp_valid", 32'(rsp_valid_o), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        set_rr_payloads();
        req_valid_i = '1;
        #1;
        check("post_reset_grant", 32'(req_ready_o), 32'h1);
        exp_q.push_back({4'b0001, rr_exp[0]});
        tick();
        req_valid_i = '0;
        wait_idle();

        // Round robin with all four valid and rsp_ready high.
        do_reset();
        set_rr_payloads();
        req_valid_i = '1;
        watch_grants(5);
        req_valid_i = '0;
        wait_idle();
        for (int i = 0; i < grant_order.size() && i < 5; i++) begin
            check("rr_order", 32'(grant_order[i]), 32'(exp_rr[i]));
            if (i > 0) check("rr_spacing", 32'(grant_cyc[i] - grant_cyc[i-1]), 32'd5);
        end

        // Requesters 0, 1, 3 valid continuously.
        do_reset();
        set_rr_payloads();
        req_valid_i = 4'b1011;
        watch_grants(4);
        req_valid_i = '0;
        wait_idle();
        for (int i = 0; i < grant_order.size() && i < 4; i++) begin
            check("prio_order", 32'(grant_order[i]), 32'(exp_prio[i]));
        end

        repeat (3) tick();
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time limit.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

endmodule
